// File: rtl/byte_encode_pkg.sv
// Shared types and constants for the streaming ByteEncode_d stage.
package byte_encode_pkg;

    localparam int unsigned D_MAX_DEFAULT = 12;
    localparam int unsigned KYBER_Q       = 3329;

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DROP} benc_state_t;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/byte_encode_stream.sv
// Packs d-bit coefficients LSB-first into a bit stream and emits it as bytes (valid/ready).
// Optional feature macro: BYTE_ENCODE_MOD_CHECK_EN (flags d=12 coefficients >= q in err_o).
module byte_encode_stream
    import byte_encode_pkg::*;
#(
    parameter int unsigned D_MAX = D_MAX_DEFAULT,
    parameter int unsigned D_W   = $clog2(D_MAX + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [D_W-1:0]   d_i,
    input  logic [D_MAX-1:0] coef_i,
    input  logic             coef_valid_i,
    input  logic             coef_last_i,
    output logic             coef_ready_o,
    output byte_t            byte_o,
    output logic             byte_valid_o,
    output logic             byte_last_o,
    input  logic             byte_ready_i,
    output logic             err_o
);

    localparam int unsigned ACC_W = D_MAX + 7;
    localparam int unsigned CNT_W = $clog2(D_MAX + 8);
    localparam logic [CNT_W-1:0] CNT_BYTE = CNT_W'(8);

    benc_state_t      state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [D_W-1:0]   d_q, d_d;
    logic             err_q, err_d;

    logic [D_W-1:0]   d_eff;
    logic [D_MAX-1:0] coef_mask;
    logic [ACC_W-1:0] coef_ext;
    logic             d_legal;
    logic             coef_fire;
    logic             byte_fire;
    logic             range_err;

    // Ready/valid derive only from registered state, never from the opposite handshake.
    always_comb begin
        coef_ready_o = 1'b0;
        byte_valid_o = 1'b0;
        case (state_q)
            IDLE, DROP: coef_ready_o = 1'b1;
            ACTIVE: begin
                coef_ready_o = (cnt_q < CNT_BYTE);
                byte_valid_o = (cnt_q >= CNT_BYTE);
            end
            FLUSH:   byte_valid_o = (cnt_q != '0);
            default: ;
        endcase
        if (rst_i) begin
            coef_ready_o = 1'b0;
            byte_valid_o = 1'b0;
        end
    end

    assign byte_o      = acc_q[7:0];
    assign byte_last_o = byte_valid_o && (state_q == FLUSH) && (cnt_q <= CNT_BYTE);
    assign err_o       = err_q;

    assign coef_fire = coef_valid_i && coef_ready_o;
    assign byte_fire = byte_valid_o && byte_ready_i;
    assign d_eff     = (state_q == IDLE) ? d_i : d_q;
    assign d_legal   = (d_i != '0) && (d_i <= D_W'(D_MAX));
    assign coef_mask = ~({D_MAX{1'b1}} << d_eff);
    assign coef_ext  = ACC_W'(coef_i & coef_mask);

`ifdef BYTE_ENCODE_MOD_CHECK_EN
    assign range_err = (d_eff == D_W'(12)) && (coef_i[11:0] >= 12'(KYBER_Q));
`else
    assign range_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (coef_fire) begin
                    if (d_legal) begin
                        acc_d   = coef_ext;
                        cnt_d   = CNT_W'(d_i);
                        d_d     = d_i;
                        err_d   = err_q | range_err;
                        state_d = coef_last_i ? FLUSH : ACTIVE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = coef_last_i ? IDLE : DROP;
                    end
                end
            end
            ACTIVE: begin
                if (coef_fire) begin
                    acc_d = acc_q | (coef_ext << cnt_q);
                    cnt_d = cnt_q + CNT_W'(d_q);
                    err_d = err_q | range_err;
                    if (coef_last_i) begin
                        state_d = FLUSH;
                    end
                end else if (byte_fire) begin
                    acc_d = acc_q >> 8;
                    cnt_d = cnt_q - CNT_BYTE;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end else if (byte_fire) begin
                    if (cnt_q <= CNT_BYTE) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d = acc_q >> 8;
                        cnt_d = cnt_q - CNT_BYTE;
                    end
                end
            end
            DROP: begin
                if (coef_fire && coef_last_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            d_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/byte_encode_stream.md
Name: byte_encode_stream

Overview:
- Streaming ByteEncode_d stage for the conversion path. Accepts d-bit coefficients one per handshake and packs them LSB-first into a continuous bit stream.
- Emits that stream as bytes over a valid/ready interface; it is the sequential producer of the byte-ordered data the combinational bits2bytes stage slices.
- The same d-bit packing serves compression outputs (d = 1, 4, 5, 10, 11) and the full-width encoding (d = 12).

Parameters:
- D_MAX, 12, maximum coefficient width in bits; sets the coef_i width and the accumulator size (D_MAX+7 bits).
- D_W, $clog2(D_MAX+1), width of the d_i field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- d_i  in  D_W  coefficient width; legal range 1..D_MAX.
- coef_i  in  D_MAX  coefficient; only bits [d-1:0] are used, upper bits are ignored.
- coef_valid_i  in  1  coefficient valid.
- coef_last_i  in  1  marks the final coefficient of a block.
- coef_ready_o  out  1  block can accept a coefficient.
- byte_o  out  8  output byte.
- byte_valid_o  out  1  output byte valid.
- byte_last_o  out  1  marks the final byte of a block.
- byte_ready_i  in  1  downstream accepts the byte.
- err_o  out  1  sticky error flag.

Interface note: one clock (clk_i); rst_i is synchronous, active-high.

Behaviour:
- Reset, synchronous on rst_i high: accumulator = 0, bit count = 0, state = IDLE, err_o = 0, byte_valid_o = 0, byte_last_o = 0, coef_ready_o = 0 during the reset cycle.
- Reset mid-block discards all partial bits; no byte and no last is emitted afterwards.
- Coefficient handshake: a transfer occurs when coef_valid_i && coef_ready_o. Byte handshake: a transfer occurs when byte_valid_o && byte_ready_i. Neither valid may depend combinationally on its own ready.
- Accumulator: acc[D_MAX+6:0] with count cnt in 0..D_MAX+7.
- On a coefficient accept: acc |= coef[d-1:0] << cnt, then cnt += d.
- On a byte accept: byte_o = acc[7:0], then acc >>= 8 and cnt -= 8. In FLUSH, cnt is instead clamped to 0.
- byte_o is driven from the register acc[7:0]. Latency is 1 cycle from the accept that completes 8 bits to byte_valid_o.
- d is latched from d_i on the first coefficient accepted in IDLE and held until the block ends; changes to d_i mid-block are ignored.
- State IDLE: cnt = 0, coef_ready_o = 1.
  - Accept with legal d and last = 0 -> ACTIVE.
  - Accept with legal d and last = 1 -> FLUSH.
  - Accept with illegal d (0 or > D_MAX): coefficient is dropped, err_o set, next state DROP (or stays IDLE if last = 1).
- State ACTIVE: coef_ready_o = (cnt < 8); byte_valid_o = (cnt >= 8), so push and pop are mutually exclusive.
  - Accepting a coefficient with last = 1 -> FLUSH.
- State FLUSH: coef_ready_o = 0; byte_valid_o = (cnt > 0).
  - A final partial byte is zero-padded in its upper bits.
  - byte_last_o = 1 on the byte for which cnt <= 8.
  - When that byte is accepted -> IDLE, with cnt = 0 and acc = 0.
  - If cnt = 0 on entry (impossible for d >= 1), go directly to IDLE.
- State DROP: coef_ready_o = 1; coefficients are consumed and discarded; a coefficient with last = 1 returns the block to IDLE. No bytes are emitted.
- Byte hold: while byte_valid_o && !byte_ready_i, byte_o and byte_last_o hold stable.
- Throughput: with d = 8 and no backpressure, one coefficient per 2 cycles.
- err_o is sticky; it is cleared only by rst_i.

Optional Feature:
- Macro: BYTE_ENCODE_MOD_CHECK_EN.
- Defined: when the latched d == 12, any accepted coefficient with coef_i[11:0] >= 3329 also sets err_o. The coefficient is still packed unchanged.
- Undefined: no range check; err_o reflects only illegal d.

Decomposition:
- Package byte_encode_pkg holds:
  - D_MAX_DEFAULT = 12;
  - KYBER_Q = 3329;
  - typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DROP} benc_state_t;
  - typedef logic [7:0] byte_t.
- Single module; no sub-module is warranted. The shift/OR accumulator is its entire datapath.

Test Plan:
- d=1; coefs 1,0,1,1,0,0,0,1, last on the 8th -> a single byte 0x8D with byte_last_o = 1; state returns to IDLE.
- d=12; coefs 0xABC, 0x123 (last) -> bytes 0xBC, 0x3A, 0x12 in that order, with last on 0x12.
- d=4; single coef 0x5 with last -> byte 0x05 (zero-padded) with byte_last_o = 1. d=11; coef 0x7FF with last -> bytes 0xFF, 0x07 with last on the second.
- Backpressure: d=10, 4 coefs 0x3FF, byte_ready_i held low for 5 cycles -> byte_o/byte_valid_o stable and coef_ready_o = 0; after release, bytes are 0xFF x5 with last on the fifth.
- Illegal d: d=0 with coefs 0x1, 0x2 (last) -> no bytes, err_o = 1 sticky. A following block with d=8 and coef 0x5A (last) -> byte 0x5A. With BYTE_ENCODE_MOD_CHECK_EN, d=12 and coef 0xD01 -> err_o = 1 and bytes 0x01, 0x0D are still emitted.
- Reset mid-block: d=5, 3 coefs accepted, then rst_i pulsed -> byte_valid_o = 0 and no last appears. A new d=8 block with coef 0xC3 (last) -> byte 0xC3 only.
